// File: rtl/park_allocator_if.sv
// ----------------------------------------------------------------------------
// park_allocator_if
//   Handshake bundle between the parking-lot entry/exit logic and the space
//   allocator.
//
//   Entry side : arrive_req (level) -> arrive_ack / grant_valid / grant_space
//   Exit side  : depart_req / depart_space (pulse) -> release_err
//   Status     : space_map, free_count, lot_full, gate_open
//
//   master : the requester (lot sensors / testbench) driving requests
//   slave  : the allocator answering them and publishing lot status
// ----------------------------------------------------------------------------
interface park_allocator_if;
    logic       arrive_req;
    logic       arrive_ack;
    logic       grant_valid;
    logic [2:0] grant_space;
    logic       depart_req;
    logic [2:0] depart_space;
    logic       release_err;
    logic [7:0] space_map;
    logic [3:0] free_count;
    logic       lot_full;
    logic       gate_open;

    modport master (
        output arrive_req, depart_req, depart_space,
        input  arrive_ack, grant_valid, grant_space, release_err,
               space_map, free_count, lot_full, gate_open
    );

    modport slave (
        input  arrive_req, depart_req, depart_space,
        output arrive_ack, grant_valid, grant_space, release_err,
               space_map, free_count, lot_full, gate_open
    );
endinterface

// File: rtl/park_allocator.sv
// ----------------------------------------------------------------------------
// park_allocator
//   Owns the free-space map of an 8-space parking lot. An arriving car is
//   granted the highest-numbered free space and the entry gate is held open
//   for GATE_CYCLES cycles; departing cars return their space. A departure
//   naming a space that is already free is flagged with release_err.
//
//   Ports
//     clk    : system clock, rising edge
//     rst_n  : synchronous active-low reset
//     bus    : park_allocator_if.slave
//                arrive_req   in  level request, held until arrive_ack
//                arrive_ack   out one-cycle answer to arrive_req
//                grant_valid  out 1 = space granted, 0 = lot full (deny)
//                grant_space  out granted index, held until next grant
//                depart_req   in  one-cycle departure pulse
//                depart_space in  index of the space being vacated
//                release_err  out one-cycle pulse, departure of a free space
//                space_map    out bit i = 1 -> space i is free
//                free_count   out popcount(space_map), 0..8
//                lot_full     out space_map == 0 (combinational)
//                gate_open    out entry gate drive
// ----------------------------------------------------------------------------
module park_allocator #(
    parameter int NUM_SPACES  = 8,
    parameter int GATE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    park_allocator_if.slave bus
);

    localparam logic [7:0] ALL_FREE    = {NUM_SPACES{1'b1}};
    localparam logic [3:0] ALL_COUNT   = 4'(NUM_SPACES);
    localparam logic [3:0] GATE_LOAD   = 4'(GATE_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] gate_cnt;

    // Highest set bit of the map; same rule as the downstream encoder.
    function automatic logic [2:0] highest_set(input logic [7:0] map);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (map[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // All decisions below look at the pre-edge map only, so a space released
    // on this edge cannot be granted on this edge, and a release of the space
    // being allocated is seen as a release of a free space (error).
    logic       alloc;
    logic [2:0] alloc_idx;
    logic       rel_ok;
    logic       rel_err;
    logic [7:0] map_next;
    logic [3:0] count_next;

    assign bus.lot_full = (bus.space_map == 8'h00);

    always_comb begin
        alloc      = (state == IDLE) && bus.arrive_req && !bus.lot_full;
        alloc_idx  = highest_set(bus.space_map);
        rel_ok     = bus.depart_req && !bus.space_map[bus.depart_space];
        rel_err    = bus.depart_req &&  bus.space_map[bus.depart_space];

        map_next   = bus.space_map;
        if (alloc)  map_next[alloc_idx]        = 1'b0;
        if (rel_ok) map_next[bus.depart_space] = 1'b1;

        count_next = bus.free_count - {3'b000, alloc} + {3'b000, rel_ok};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            gate_cnt        <= '0;
            bus.space_map   <= ALL_FREE;
            bus.free_count  <= ALL_COUNT;
            bus.grant_space <= '0;
            bus.arrive_ack  <= 1'b0;
            bus.grant_valid <= 1'b0;
            bus.release_err <= 1'b0;
            bus.gate_open   <= 1'b0;
        end else begin
            // Departures are serviced in every state.
            bus.space_map   <= map_next;
            bus.free_count  <= count_next;
            bus.release_err <= rel_err;

            // Ack and its qualifier are single-cycle pulses.
            bus.arrive_ack  <= 1'b0;
            bus.grant_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.arrive_req) begin
                        bus.arrive_ack <= 1'b1;
                        if (alloc) begin
                            bus.grant_valid <= 1'b1;
                            bus.grant_space <= alloc_idx;
                            bus.gate_open   <= 1'b1;
                            gate_cnt        <= GATE_LOAD;
                            state           <= GATE;
                        end else begin
                            state <= WAIT_REL;
                        end
                    end
                end

                GATE: begin
                    // Gate was raised on the grant edge with the counter at
                    // GATE_CYCLES; dropping it as the counter leaves 1 gives
                    // exactly GATE_CYCLES high cycles.
                    gate_cnt <= gate_cnt - 4'd1;
                    if (gate_cnt <= 4'd1) begin
                        bus.gate_open <= 1'b0;
                        state         <= WAIT_REL;
                    end
                end

                WAIT_REL: begin
                    // A held request must be withdrawn before it can be
                    // answered again.
                    if (!bus.arrive_req) state <= IDLE;
                end

                default: begin
                    state         <= IDLE;
                    bus.gate_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_park_allocator.sv
module tb_park_allocator;
    localparam int G = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    park_allocator_if bus_i ();

    park_allocator #(.NUM_SPACES(8), .GATE_CYCLES(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit model_on = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the lot as a set of free spaces plus "this request already
    // answered" and "cycles of gate left".
    bit m_free [8];
    bit m_ack, m_valid, m_err, m_served;
    int m_space, m_gate_left;

    always @(posedge clk) begin
        bit pre [8];
        int hi;
        bit ack, valid, served_n;
        int ds;
        if (!rst_n) begin
            foreach (m_free[i]) m_free[i] = 1;
            m_ack = 0; m_valid = 0; m_err = 0; m_served = 0;
            m_space = 0; m_gate_left = 0;
        end else begin
            pre = m_free;
            hi = -1;
            for (int i = 0; i < 8; i++) if (pre[i]) hi = i;
            ack   = !m_served && bus_i.arrive_req;
            valid = ack && (hi >= 0);
            served_n = m_served;
            if (ack) served_n = 1;
            else if (m_served && m_gate_left == 0 && !bus_i.arrive_req) served_n = 0;
            if (valid) m_gate_left = G;
            else if (m_gate_left > 0) m_gate_left--;
            ds = int'(bus_i.depart_space);
            if (valid) begin
                m_free[hi] = 0;
                m_space = hi;
            end
            m_err = bus_i.depart_req && pre[ds];
            if (bus_i.depart_req && !pre[ds]) m_free[ds] = 1;
            m_ack = ack; m_valid = valid; m_served = served_n;
        end
    end

    function automatic int model_map();
        int v = 0;
        for (int i = 0; i < 8; i++) if (m_free[i]) v += (1 << i);
        return v;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_free[i]);
        return c;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_on) begin
            check("space_map",   int'(bus_i.space_map),   model_map());
            check("free_count",  int'(bus_i.free_count),  model_count());
            check("lot_full",    int'(bus_i.lot_full),    int'(model_map() == 0));
            check("gate_open",   int'(bus_i.gate_open),   int'(m_gate_left > 0));
            check("arrive_ack",  int'(bus_i.arrive_ack),  int'(m_ack));
            check("grant_valid", int'(bus_i.grant_valid), int'(m_valid));
            check("grant_space", int'(bus_i.grant_space), m_space);
            check("release_err", int'(bus_i.release_err), int'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    // Raise arrive_req, wait for the ack, drop it and let the gate finish.
    task automatic arrive(output bit valid, output int space, output bit gate_seen);
        bit got;
        got = 0; valid = 0; space = -1; gate_seen = 0;
        bus_i.arrive_req = 1;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (bus_i.arrive_ack) begin
                got = 1;
                valid = bus_i.grant_valid;
                space = int'(bus_i.grant_space);
                gate_seen = bus_i.gate_open;
            end
        end
        if (!got) check("arrive_timeout", 0, 1);
        bus_i.arrive_req = 0;
        repeat (G + 3) begin
            tick();
            if (bus_i.gate_open) gate_seen = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit v, gs;
        int sp, gcnt, acks;
        bus_i.arrive_req = 0;
        bus_i.depart_req = 0;
        bus_i.depart_space = '0;

        // 1: reset, first grant, gate width, no second ack while held
        do_reset();
        model_on = 1;
        check("rst_map",   int'(bus_i.space_map), 8'hFF);
        check("rst_count", int'(bus_i.free_count), 8);
        check("rst_gate",  int'(bus_i.gate_open), 0);
        check("rst_ack",   int'(bus_i.arrive_ack), 0);
        bus_i.arrive_req = 1;
        tick();
        check("t1_ack",   int'(bus_i.arrive_ack), 1);
        check("t1_valid", int'(bus_i.grant_valid), 1);
        check("t1_space", int'(bus_i.grant_space), 7);
        check("t1_map",   int'(bus_i.space_map), 8'h7F);
        check("t1_count", int'(bus_i.free_count), 7);
        gcnt = int'(bus_i.gate_open);
        acks = 0;
        repeat (12) begin
            tick();
            gcnt += int'(bus_i.gate_open);
            acks += int'(bus_i.arrive_ack);
        end
        check("t1_gate_cycles", gcnt, 4);
        check("t1_no_second_ack", acks, 0);
        bus_i.arrive_req = 0;
        tick();
        tick();

        // 2: fill the lot, then deny
        for (int s = 6; s >= 0; s--) begin
            arrive(v, sp, gs);
            check("t2_valid", int'(v), 1);
            check("t2_space", sp, s);
        end
        check("t2_map",   int'(bus_i.space_map), 0);
        check("t2_full",  int'(bus_i.lot_full), 1);
        check("t2_count", int'(bus_i.free_count), 0);
        arrive(v, sp, gs);
        check("t2_deny_valid", int'(v), 0);
        check("t2_deny_gate",  int'(gs), 0);

        // 3: release space 3 from full, regrant it
        bus_i.depart_req = 1; bus_i.depart_space = 3'd3;
        tick();
        bus_i.depart_req = 0;
        check("t3_map",   int'(bus_i.space_map), 8'h08);
        check("t3_count", int'(bus_i.free_count), 1);
        arrive(v, sp, gs);
        check("t3_space", sp, 3);
        check("t3_full",  int'(bus_i.lot_full), 1);

        // 4: release of an already free space
        do_reset();
        bus_i.depart_req = 1; bus_i.depart_space = 3'd5;
        tick();
        bus_i.depart_req = 0;
        check("t4_err",   int'(bus_i.release_err), 1);
        check("t4_map",   int'(bus_i.space_map), 8'hFF);
        check("t4_count", int'(bus_i.free_count), 8);
        tick();
        check("t4_err_pulse", int'(bus_i.release_err), 0);

        // 5: full lot, arrival and release on the same edge
        for (int s = 7; s >= 0; s--) arrive(v, sp, gs);
        check("t5_full", int'(bus_i.lot_full), 1);
        bus_i.arrive_req = 1;
        bus_i.depart_req = 1; bus_i.depart_space = 3'd2;
        tick();
        bus_i.depart_req = 0;
        check("t5_ack",   int'(bus_i.arrive_ack), 1);
        check("t5_valid", int'(bus_i.grant_valid), 0);
        check("t5_map",   int'(bus_i.space_map), 8'h04);
        bus_i.arrive_req = 0;
        tick();
        tick();
        arrive(v, sp, gs);
        check("t5_regrant", sp, 2);

        // 6: reset during GATE with request held
        do_reset();
        bus_i.arrive_req = 1;
        tick();
        tick();
        check("t6_in_gate", int'(bus_i.gate_open), 1);
        rst_n = 0;
        tick();
        check("t6_gate", int'(bus_i.gate_open), 0);
        check("t6_map",  int'(bus_i.space_map), 8'hFF);
        check("t6_count", int'(bus_i.free_count), 8);
        rst_n = 1;
        tick();
        check("t6_ack",   int'(bus_i.arrive_ack), 1);
        check("t6_space", int'(bus_i.grant_space), 7);
        bus_i.arrive_req = 0;
        repeat (G + 3) tick();

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 15) bus_i.arrive_req = ~bus_i.arrive_req;
            bus_i.depart_req   = ($urandom_range(0, 99) < 30);
            bus_i.depart_space = 3'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1;
        bus_i.depart_req = 0;
        bus_i.arrive_req = 0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
